seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 16, sets the operand and result bit width (legal range 4..32).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: dividend  input  WIDTH  numerator; captured on the accepted start edge.
REQ-006 Port: divisor  input  WIDTH  denominator; captured on the accepted start edge.
REQ-007 Port: busy  output  1  high from the cycle after an accepted start until done is high.
REQ-008 Port: done  output  1  single-cycle pulse when results are valid.
REQ-009 Port: quotient  output  WIDTH  registered quotient.
REQ-010 Port: remainder  output  WIDTH  registered remainder.
REQ-011 Port: div_by_zero  output  1  high with done when the captured divisor is 0; holds until the next accepted start.

Function
REQ-012 The module SHALL implement a restoring shift-subtract divider with an internal datapath of A (WIDTH), R (WIDTH+1), D (WIDTH) and an iteration counter of $clog2(WIDTH)+1 bits.
REQ-013 The FSM SHALL have the states IDLE, ITER, FIX, DONE.
REQ-014 IDLE: start=1 SHALL capture the operands, clear R, load the counter with WIDTH, and go to ITER; if divisor==0, it SHALL go to DONE instead.
REQ-015 ITER: each cycle SHALL shift {R,A} left by 1, compute R-D, keep the difference and set A[0]=1 if its MSB is 0, otherwise restore R and set A[0]=0, then decrement the counter.
REQ-016 ITER SHALL exit to FIX when the counter reaches 0 after exactly WIDTH iterations.
REQ-017 FIX SHALL register quotient=A and remainder=R[WIDTH-1:0], apply any sign correction (REQ-025), and go to DONE.
REQ-018 DONE SHALL assert done for one cycle, deassert busy, and return to IDLE.
REQ-019 Latency: for a nonzero divisor, done SHALL be high in the cycle WIDTH+2 edges after the start edge. For a zero divisor, done SHALL be high 1 edge after the start edge.
REQ-020 Divide-by-zero: quotient SHALL be all ones, remainder SHALL be the dividend, and div_by_zero SHALL be 1.
REQ-021 While busy, start SHALL be ignored, and input changes SHALL NOT affect the operation in flight.
REQ-022 start high in the DONE cycle SHALL be ignored; start high in the following IDLE cycle SHALL be accepted, giving back-to-back throughput of one result per WIDTH+3 cycles.
REQ-023 quotient, remainder and div_by_zero SHALL hold their last values until the FIX or DONE update of the next operation.

Reset
REQ-024 reset_n=0 SHALL, immediately and regardless of state (including mid-ITER), force IDLE, clear busy, done, quotient, remainder, div_by_zero, A, R, D and the counter to 0, and abandon the operation in flight with no done pulse; after reset_n rises, the first accepted start needs one clock edge.

Configuration
REQ-025 Macro SEQ_DIVIDER_SIGNED_EN defined: operands SHALL be two's complement and divided as magnitudes, the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the dividend's sign (truncation toward zero); the most-negative value divided by -1 SHALL give quotient = most-negative value and remainder = 0; divide-by-zero SHALL follow REQ-020 unchanged.
REQ-026 Macro SEQ_DIVIDER_SIGNED_EN undefined: all operands SHALL be unsigned, and FIX SHALL perform no sign correction (its one-cycle latency is retained).

Verification
REQ-027 WIDTH=16, unsigned: dividend=100, divisor=7, start pulse -> busy for 17 cycles; done at start edge+18; quotient=14, remainder=2, div_by_zero=0.
REQ-028 Zero divisor: dividend=1234, divisor=0 -> done at start edge+1; quotient=0xFFFF, remainder=1234, div_by_zero=1.
REQ-029 Inputs changed to 50/5 and start pulsed mid-operation of 100/7 -> result still 14 r 2, exactly one done; a start after done returns 10 r 0.
REQ-030 Edge cases: 0xFFFF/1 -> 0xFFFF r 0; 5/9 -> 0 r 5; back-to-back starts -> results separated by 19 cycles.
REQ-031 reset_n low for 1 cycle at iteration 8 of 100/7 -> all outputs 0, no done; a new 9/3 -> 3 r 0 with full latency.
REQ-032 With SEQ_DIVIDER_SIGNED_EN: -7/2 -> 0xFFFD r 0xFFFF; 7/-2 -> 0xFFFD r 1; 0x8000/0xFFFF -> 0x8000 r 0.

Source files
------------

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, WIDTH+3 cycles per result.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_dz;

  logic             w_dz;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH+1:0] w_sh;
  logic [WIDTH+1:0] w_diff;

  assign w_dz   = (divisor == '0);
  assign w_sh   = {r_r, r_a[WIDTH-1]};
  assign w_diff = w_sh - {2'b00, r_d};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_nq;
  logic r_nr;

  // Magnitudes are divided unsigned; most-negative maps onto itself.
  assign w_a_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign w_b_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
  assign w_q_fix = r_nq ? (~r_a + WIDTH'(1)) : r_a;
  assign w_r_fix = r_nr ? (~r_r[WIDTH-1:0] + WIDTH'(1))
                        : r_r[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nq <= 1'b0;
      r_nr <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_nq <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_nr <= dividend[WIDTH-1];
    end
  end
`else
  assign w_a_mag = dividend;
  assign w_b_mag = divisor;
  assign w_q_fix = r_a;
  assign w_r_fix = r_r[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= w_dz ? dividend : w_a_mag;
            r_d     <= w_b_mag;
            r_r     <= '0;
            r_cnt   <= CW'(WIDTH);
            r_dz    <= w_dz;
            busy    <= 1'b1;
            r_state <= w_dz ? DONE : ITER;
          end
        end
        ITER: begin
          if (!w_diff[WIDTH+1]) begin
            r_r <= w_diff[WIDTH:0];
            r_a <= {r_a[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= w_sh[WIDTH:0];
            r_a <= {r_a[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          quotient    <= w_q_fix;
          remainder   <= w_r_fix;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          r_state     <= DONE;
        end
        DONE: begin
          // Zero-divisor results bypass FIX and land here.
          if (r_dz) begin
            quotient    <= '1;
            remainder   <= r_a;
            div_by_zero <= 1'b1;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random
// operands checked against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int ncmp  = 0;
  int nfail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] q,
                                output logic [W-1:0] r,
                                output logic dz);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
`endif
    dz = (b == 0);
    if (dz) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Called at a negedge; start is sampled on the next posedge (k=0).
  // Observation k is taken at the negedge after edge k.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input int poke, input int rst_at,
                     output int lat, output int bcnt,
                     output int dcnt, output time tdone);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat      = -1;
    bcnt     = 0;
    dcnt     = 0;
    tdone    = 0;
    @(posedge clk);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == poke) begin
        dividend = W'(50);
        divisor  = W'(5);
        start    = 1'b1;
      end
      if (k == poke + 1) start = 1'b0;
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
      end
      if (k == rst_at + 1) reset_n = 1'b1;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) begin
          lat   = k;
          tdone = $time;
        end
      end
      if (lat >= 0 && poke < 0 && rst_at < 0) break;
    end
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic edz);
    int  lat;
    int  bc;
    int  dc;
    time t;
    run(a, b, -1, -1, lat, bc, dc, t);
    chk({tag, "_lat"}, 32'(lat), (b == 0) ? 32'd1 : 32'(W + 2));
    chk({tag, "_busy"}, 32'(bc), (b == 0) ? 32'd1 : 32'(W + 1));
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
  endtask

  initial begin
    int           lat;
    int           bc;
    int           dc;
    time          t1;
    time          t2;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    logic         mdz;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_q", 32'(quotient), 32'd0);
    chk("init_r", 32'(remainder), 32'd0);
    chk("init_dz", 32'(div_by_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    check_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    check_op("dzero", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
    check_op("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    check_op("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);

    run(16'd100, 16'd7, 5, -1, lat, bc, dc, t1);
    chk("poke_lat", 32'(lat), 32'(W + 2));
    chk("poke_dcnt", 32'(dc), 32'd1);
    chk("poke_q", 32'(quotient), 32'd14);
    chk("poke_r", 32'(remainder), 32'd2);
    check_op("d50_5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0);

    run(16'd20, 16'd3, -1, -1, lat, bc, dc, t1);
    chk("b2b1_q", 32'(quotient), 32'd6);
    chk("b2b1_r", 32'(remainder), 32'd2);
    run(16'd30, 16'd4, -1, -1, lat, bc, dc, t2);
    chk("b2b2_q", 32'(quotient), 32'd7);
    chk("b2b2_r", 32'(remainder), 32'd2);
    chk("b2b_gap", 32'(t2 - t1), 32'd190);

    run(16'd100, 16'd7, -1, 8, lat, bc, dc, t1);
    chk("rst_nodone", 32'(dc), 32'd0);
    chk("rst_q_after", 32'(quotient), 32'd0);
    check_op("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    check_op("s_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0);
    check_op("s_7_m2", 16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0);
    check_op("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      if (i % 8 == 0) b = '0;
      else if (i % 3 == 0) b = W'($urandom_range(1, 15));
      else b = W'($urandom);
      model(a, b, mq, mr, mdz);
      check_op("rand", a, b, mq, mr, mdz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
